// File: rtl/hex_ascii_serializer.sv
// rtl/hex_ascii_serializer.sv - result word to ASCII hex character stream with optional CR/LF
module hex_ascii_serializer #(
   parameter int DATA_W      = 32,
   parameter int MSB_FIRST   = 1,
   parameter int LOWER_CASE  = 0,
   parameter int SUPPRESS_LZ = 0,
   parameter int APPEND_CRLF = 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam int NIB = DATA_W / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] TOP_IDX = IW'(NIB - 1);
   localparam logic [IW-1:0] ONE_IDX = IW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HEX  = 2'd1,
      S_CR   = 2'd2,
      S_LF   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_word;
   logic [DATA_W-1:0] w_word_nxt;
   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     w_idx_nxt;
   logic [IW-1:0]     r_end;
   logic [IW-1:0]     w_end_nxt;
   logic [IW-1:0]     w_hi;
   logic [7:0]        r_out_data;
   logic [7:0]        w_out_data_nxt;
   logic              r_out_valid;
   logic              w_out_valid_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic              w_accept;
   logic [3:0]        w_nib_nxt;

   // ASCII code of one hex digit, letter case chosen at elaboration
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      logic [7:0] v;
      v = {4'h0, n};
      if (n < 4'd10) begin
         return 8'h30 + v;
      end else if (LOWER_CASE != 0) begin
         return 8'h61 + v - 8'd10;
      end else begin
         return 8'h41 + v - 8'd10;
      end
   endfunction

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign done      = r_done;
   assign w_accept  = r_out_valid & out_ready;

   // Highest non-zero nibble of the incoming word; 0 for an all-zero word
   always_comb begin
      w_hi = '0;
      for (int i = 0; i < NIB; i++) begin
         if (in_data[i*4 +: 4] != 4'h0) begin
            w_hi = IW'(i);
         end
      end
   end

   // Next-state logic plus the next registered output character
   always_comb begin
      w_state_nxt     = r_state;
      w_word_nxt      = r_word;
      w_idx_nxt       = r_idx;
      w_end_nxt       = r_end;
      w_done_nxt      = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_out_data_nxt  = 8'h00;
      w_nib_nxt       = 4'h0;

      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_word_nxt  = in_data;
               w_state_nxt = S_HEX;
               if (MSB_FIRST != 0) begin
                  w_idx_nxt = (SUPPRESS_LZ != 0) ? w_hi : TOP_IDX;
                  w_end_nxt = '0;
               end else begin
                  w_idx_nxt = '0;
                  w_end_nxt = (SUPPRESS_LZ != 0) ? w_hi : TOP_IDX;
               end
            end
         end
         S_HEX: begin
            if (w_accept) begin
               if (r_idx == r_end) begin
                  if (APPEND_CRLF != 0) begin
                     w_state_nxt = S_CR;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_done_nxt  = 1'b1;
                  end
               end else if (MSB_FIRST != 0) begin
                  w_idx_nxt = r_idx - ONE_IDX;
               end else begin
                  w_idx_nxt = r_idx + ONE_IDX;
               end
            end
         end
         S_CR: begin
            if (w_accept) begin
               w_state_nxt = S_LF;
            end
         end
         S_LF: begin
            if (w_accept) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Outputs are precomputed from the next state so they can be registered
      w_nib_nxt = 4'(w_word_nxt >> {w_idx_nxt, 2'b00});
      case (w_state_nxt)
         S_HEX: begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = hex_char(w_nib_nxt);
         end
         S_CR: begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = 8'h0D;
         end
         S_LF: begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = 8'h0A;
         end
         default: begin
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = 8'h00;
         end
      endcase
   end

   // State, shadow word, nibble range and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_word      <= '0;
         r_idx       <= '0;
         r_end       <= '0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_word      <= w_word_nxt;
         r_idx       <= w_idx_nxt;
         r_end       <= w_end_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_done      <= w_done_nxt;
      end
   end

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// tb/tb_hex_ascii_serializer.sv - randomized model-checked bench over four serializer configurations
module tb_hex_ascii_serializer;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        in_valid_a  [4];
   logic [63:0] in_data_a   [4];
   logic        in_ready_a  [4];
   logic [7:0]  out_data_a  [4];
   logic        out_valid_a [4];
   logic        out_ready_a [4];
   logic        busy_a      [4];
   logic        done_a      [4];

   int          checks = 0;
   int          failures = 0;
   logic        timeout_flag = 1'b0;

   always #5 clk = ~clk;

   // config 0: defaults; 1: leading-zero suppression; 2: LSB first, no CR/LF; 3: 8-bit lower case
   function automatic int cfg_dw(input int g);   return (g == 3) ? 8 : 32; endfunction
   function automatic int cfg_msb(input int g);  return (g == 2) ? 0 : 1;  endfunction
   function automatic int cfg_lc(input int g);   return (g == 3) ? 1 : 0;  endfunction
   function automatic int cfg_slz(input int g);  return (g == 1) ? 1 : 0;  endfunction
   function automatic int cfg_crlf(input int g); return (g == 2) ? 0 : 1;  endfunction

   for (genvar g = 0; g < 4; g++) begin : gen_dut
      localparam int DW = cfg_dw(g);
      hex_ascii_serializer #(
         .DATA_W      (DW),
         .MSB_FIRST   (cfg_msb(g)),
         .LOWER_CASE  (cfg_lc(g)),
         .SUPPRESS_LZ (cfg_slz(g)),
         .APPEND_CRLF (cfg_crlf(g))
      ) u_dut (
         .clk       (clk),
         .n_rst     (n_rst),
         .in_valid  (in_valid_a[g]),
         .in_data   (in_data_a[g][DW-1:0]),
         .in_ready  (in_ready_a[g]),
         .out_data  (out_data_a[g]),
         .out_valid (out_valid_a[g]),
         .out_ready (out_ready_a[g]),
         .busy      (busy_a[g]),
         .done      (done_a[g])
      );
   end

   // Expected frame as text: print the word in hex, trim, recase, reorder, terminate
   function automatic string model(input logic [63:0] w, input int g);
      string s;
      string r;
      int    nib;
      nib = cfg_dw(g) / 4;
      s = $sformatf("%016h", w);
      s = s.substr(16 - nib, 15);
      if (cfg_slz(g) != 0) begin
         while (s.len() > 1 && s[0] == 8'h30) s = s.substr(1, s.len() - 1);
      end
      if (cfg_lc(g) == 0) s = s.toupper();
      if (cfg_msb(g) == 0) begin
         r = "";
         for (int i = s.len() - 1; i >= 0; i--) r = {r, s.substr(i, i)};
         s = r;
      end
      if (cfg_crlf(g) != 0) s = $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
      return s;
   endfunction

   function automatic string to_hex(input string s);
      string r;
      r = "";
      for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
      return r;
   endfunction

   task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, g, act, exp, $time);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=[%s] required=[%s]", name, to_hex(act), to_hex(exp));
      end
   endtask

   string exp_s      [4];
   int    exp_pos    [4];
   logic  exp_done   [4];
   logic  prev_stall [4];
   logic  [7:0] prev_data [4];
   logic  pinned = 1'b0;

   // Compare process: every negedge, DUT outputs versus the text model
   always @(negedge clk) begin
      string crlf;
      string cur;
      logic  pend;
      if (!pinned) begin
         crlf = $sformatf("%c%c", 8'h0D, 8'h0A);
         chk_str("pin_1234abcd",  model(64'h1234ABCD, 0), {"1234ABCD", crlf});
         chk_str("pin_slz_f0",    model(64'h000000F0, 1), {"F0", crlf});
         chk_str("pin_slz_zero",  model(64'h0, 1),        {"0", crlf});
         chk_str("pin_slz_8000",  model(64'h80000000, 1), {"80000000", crlf});
         chk_str("pin_lsb_first", model(64'h1234ABCD, 2), "DCBA4321");
         chk_str("pin_lower_8b",  model(64'hAF, 3),       {"af", crlf});
         pinned = 1'b1;
      end
      chk("timeout", 0, timeout_flag, 0);
      for (int g = 0; g < 4; g++) begin
         if (!n_rst) begin
            chk("rst_out_valid", g, out_valid_a[g], 0);
            chk("rst_in_ready",  g, in_ready_a[g], 1);
            chk("rst_busy",      g, busy_a[g], 0);
            chk("rst_done",      g, done_a[g], 0);
            chk("rst_out_data",  g, out_data_a[g], 0);
            exp_s[g]      = "";
            exp_pos[g]    = 0;
            exp_done[g]   = 1'b0;
            prev_stall[g] = 1'b0;
         end else begin
            cur  = exp_s[g];
            pend = (exp_pos[g] < cur.len());
            chk("out_valid", g, out_valid_a[g], pend);
            chk("in_ready",  g, in_ready_a[g], !pend);
            chk("busy",      g, busy_a[g], pend);
            chk("done",      g, done_a[g], exp_done[g]);
            if (prev_stall[g]) chk("stall_hold", g, out_data_a[g], prev_data[g]);
            if (pend) chk("out_data", g, out_data_a[g], cur[exp_pos[g]]);
            exp_done[g]   = 1'b0;
            prev_stall[g] = out_valid_a[g] && !out_ready_a[g];
            prev_data[g]  = out_data_a[g];
            if (pend && out_ready_a[g]) begin
               exp_pos[g]++;
               if (exp_pos[g] == cur.len()) exp_done[g] = 1'b1;
            end
            if (in_valid_a[g] && !pend) begin
               exp_s[g]   = model(in_data_a[g], g);
               exp_pos[g] = 0;
            end
         end
      end
   end

   logic [63:0] lst  [4][0:3];
   int          lcnt [4];

   // Present each DUT's word list (in_valid held through frames), wait until all idle
   task automatic send_lists(input bit rnd);
      int   pos [4];
      logic acc [4];
      int   cyc;
      bit   active;
      for (int g = 0; g < 4; g++) pos[g] = 0;
      cyc = 0;
      do begin
         for (int g = 0; g < 4; g++) begin
            if (pos[g] < lcnt[g]) begin
               in_valid_a[g] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
               in_data_a[g]  = lst[g][pos[g]];
            end else begin
               in_valid_a[g] = 1'b0;
               in_data_a[g]  = {$urandom, $urandom};
            end
            out_ready_a[g] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         @(negedge clk);
         for (int g = 0; g < 4; g++) acc[g] = in_valid_a[g] && in_ready_a[g];
         @(posedge clk);
         #1;
         active = 1'b0;
         for (int g = 0; g < 4; g++) begin
            if (acc[g]) pos[g]++;
            if (pos[g] < lcnt[g] || !in_ready_a[g]) active = 1'b1;
         end
         cyc++;
      end while (active && cyc < 3000);
      for (int g = 0; g < 4; g++) begin
         in_valid_a[g]  = 1'b0;
         out_ready_a[g] = 1'b1;
      end
      if (active) timeout_flag = 1'b1;
   endtask

   task automatic set_all(input logic [63:0] w);
      for (int g = 0; g < 4; g++) begin
         lst[g][0] = w;
         lcnt[g]   = 1;
      end
   endtask

   initial begin
      for (int g = 0; g < 4; g++) begin
         in_valid_a[g]  = 1'b0;
         in_data_a[g]   = 64'h0;
         out_ready_a[g] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b1;
      @(posedge clk);
      #1;

      // directed frames at full throughput
      lst[0][0] = 64'h1234ABCD; lst[0][1] = 64'hDEADBEEF; lcnt[0] = 2;
      lst[1][0] = 64'h000000F0; lst[1][1] = 64'h0;        lst[1][2] = 64'h80000000; lst[1][3] = 64'h1; lcnt[1] = 4;
      lst[2][0] = 64'h1234ABCD; lst[2][1] = 64'h0;        lcnt[2] = 2;
      lst[3][0] = 64'hAF;       lst[3][1] = 64'h5C;       lcnt[3] = 2;
      send_lists(1'b0);

      // same word with random output stalls
      set_all(64'h1234ABCD);
      send_lists(1'b1);

      // random words, biased toward leading zeros, random stalls and valid gaps
      for (int it = 0; it < 40; it++) begin
         for (int g = 0; g < 4; g++) begin
            lcnt[g] = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) lst[g][k] = {$urandom, $urandom} >> $urandom_range(0, 63);
         end
         send_lists(it[0]);
      end

      // abort a frame with reset after three accepted characters
      for (int g = 0; g < 4; g++) begin
         in_valid_a[g]  = 1'b1;
         in_data_a[g]   = 64'h1234ABCD;
         out_ready_a[g] = 1'b1;
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) in_valid_a[g] = 1'b0;
      repeat (3) @(posedge clk);
      #2 n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b1;
      @(posedge clk);
      #1;
      set_all(64'h00C0FFEE);
      send_lists(1'b0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
